hiscore_upload: RTL and testbench



---
 rtl/hiscore_pkg.sv | 8 +
 rtl/hiscore_upload.sv | 108 ++++++++++
 tb/tb_hiscore_upload.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/hiscore_pkg.sv
// Shared types and constants for the high-score/NVRAM upload reader.
package hiscore_pkg;
  typedef enum logic [1:0] {IDLE, PAUSE, READY, FETCH} state_t;

  localparam logic [7:0] FILL_BYTE = 8'hFF;
  localparam logic [7:0] DEF_INDEX = 8'd4;
  localparam int         LAT_W     = 3;
endpackage

// File: rtl/hiscore_upload.sv
// Streams NVRAM bytes onto ioctl_din for HPS upload requests, holding the CPU paused.
// Define HISCORE_UPLOAD_CHECKSUM_EN to add an 8-bit running sum output of fetched bytes.
module hiscore_upload
  import hiscore_pkg::*;
#(
  parameter int         ADDR_W  = 10,
  parameter int         SIZE    = 1024,
  parameter int         RAM_LAT = 2,
  parameter logic [7:0] INDEX   = DEF_INDEX
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_q,
  output logic              pause_req,
  input  logic              pause_ack,
  output logic              busy,
  output logic              done
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
  ,
  output logic [7:0]        checksum
`endif
);

  state_t           state, next;
  logic             active, active_q, in_range, fetch_done;
  logic [LAT_W-1:0] cnt;

  assign active     = ioctl_upload && (ioctl_index == INDEX);
  assign in_range   = ioctl_addr < 25'(SIZE);
  assign fetch_done = (state == FETCH) && (cnt == '0);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  // Session end is tested as a level, so a drop during FETCH is seen once back in READY.
  always_comb begin
    next       = state;
    pause_req  = 1'b0;
    ioctl_wait = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: if (active && !active_q) next = PAUSE;
      PAUSE: begin
        pause_req  = 1'b1;
        ioctl_wait = 1'b1;
        busy       = 1'b1;
        if (!active)        next = IDLE;
        else if (pause_ack) next = READY;
      end
      READY: begin
        pause_req = 1'b1;
        busy      = 1'b1;
        if (!active)                   next = IDLE;
        else if (ioctl_rd && in_range) next = FETCH;
      end
      FETCH: begin
        pause_req  = 1'b1;
        ioctl_wait = 1'b1;
        busy       = 1'b1;
        if (cnt == '0) next = READY;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      active_q  <= 1'b0;
      ioctl_din <= 8'h00;
      ram_addr  <= '0;
      ram_rd    <= 1'b0;
      cnt       <= '0;
      done      <= 1'b0;
    end else begin
      active_q <= active;
      ram_rd   <= 1'b0;
      done     <= (state != IDLE) && (next == IDLE);
      if (state == READY && next == FETCH) begin
        ram_rd   <= 1'b1;
        ram_addr <= ioctl_addr[ADDR_W-1:0];
        cnt      <= LAT_W'(RAM_LAT);
      end else if (state == FETCH && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (state == READY && active && ioctl_rd && !in_range) ioctl_din <= FILL_BYTE;
      if (fetch_done) ioctl_din <= ram_q;
    end
  end

`ifdef HISCORE_UPLOAD_CHECKSUM_EN
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                              checksum <= 8'h00;
    else if (state == IDLE && next == PAUSE) checksum <= 8'h00;
    else if (fetch_done)                    checksum <= checksum + ram_q;
  end
`endif

endmodule

// File: tb/tb_hiscore_upload.sv
// Directed bench for hiscore_upload with a behavioural RAM of RAM_LAT read latency.
module tb_hiscore_upload;
  localparam int ADDR_W  = 10;
  localparam int SIZE    = 1024;
  localparam int RAM_LAT = 2;

  logic              clk_sys = 1'b0;
  logic              reset = 1'b1;
  logic              ioctl_upload, ioctl_rd, pause_ack;
  logic [7:0]        ioctl_index;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_din, ram_q;
  logic              ioctl_wait, ram_rd, pause_req, busy, done;
  logic [ADDR_W-1:0] ram_addr;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
  logic [7:0]        checksum;
`endif

  logic [7:0] mem [0:SIZE-1];
  logic [7:0] qpipe [RAM_LAT];
  int errors = 0, checks = 0;
  int rd_cnt = 0, done_cnt = 0;

  always #5 clk_sys = ~clk_sys;

  hiscore_upload #(.ADDR_W(ADDR_W), .SIZE(SIZE), .RAM_LAT(RAM_LAT), .INDEX(8'd4)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_q(ram_q), .pause_req(pause_req),
    .pause_ack(pause_ack), .busy(busy), .done(done)
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  // Data read with address A during cycle c is on ram_q during cycle c+RAM_LAT.
  always @(posedge clk_sys) begin
    qpipe[0] <= mem[ram_addr];
    for (int i = 1; i < RAM_LAT; i++) qpipe[i] <= qpipe[i-1];
    if (ram_rd) rd_cnt <= rd_cnt + 1;
    if (done)   done_cnt <= done_cnt + 1;
  end
  assign ram_q = qpipe[RAM_LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_read(input logic [24:0] a, output int stalls);
    ioctl_rd = 1'b1; ioctl_addr = a;
    step;
    ioctl_rd = 1'b0;
    stalls = 0;
    while (ioctl_wait && stalls < 20) begin
      stalls++;
      step;
    end
  endtask

  initial begin
    int n, r0, d0;
    ioctl_upload = 1'b0; ioctl_index = 8'd4; ioctl_rd = 1'b0; ioctl_addr = '0; pause_ack = 1'b0;
    for (int i = 0; i < SIZE; i++) mem[i] = 8'(i) ^ 8'h33;
    mem[0] = 8'h5A; mem[5] = 8'hA7; mem[6] = 8'h11; mem[7] = 8'h3C;

    #12;
    chk("rst_din", ioctl_din, 8'h00);
    chk("rst_wait", ioctl_wait, 1'b0);
    chk("rst_pause", pause_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ramrd", ram_rd, 1'b0);
    chk("rst_ramaddr", ram_addr, 0);

    @(posedge clk_sys); #1;
    reset = 1'b0; ioctl_upload = 1'b1;
    step;
    chk("pause_req", pause_req, 1'b1);
    chk("pause_wait", ioctl_wait, 1'b1);
    chk("pause_busy", busy, 1'b1);
    step;
    chk("pause_hold_wait", ioctl_wait, 1'b1);
    pause_ack = 1'b1;
    step;
    chk("ready_wait", ioctl_wait, 1'b0);
    chk("ready_pause", pause_req, 1'b1);

    // In-range read at address 0
    r0 = rd_cnt;
    ioctl_rd = 1'b1; ioctl_addr = 25'd0;
    step;
    ioctl_rd = 1'b0;
    chk("f_ramrd", ram_rd, 1'b1);
    chk("f_ramaddr", ram_addr, 0);
    n = 0;
    while (ioctl_wait && n < 20) begin n++; step; end
    chk("f_stalls", n, 3);
    chk("f_din", ioctl_din, 8'h5A);
    chk("f_rdcnt", rd_cnt - r0, 1);

    // Last valid byte, then out of range at SIZE and with only bit 24 set
    do_read(25'd1023, n);
    chk("last_stalls", n, 3);
    chk("last_din", ioctl_din, 8'hCC);
    r0 = rd_cnt;
    do_read(25'd1024, n);
    chk("oor_stalls", n, 0);
    chk("oor_din", ioctl_din, 8'hFF);
    do_read(25'h1000000, n);
    chk("oor_hi_stalls", n, 0);
    chk("oor_hi_din", ioctl_din, 8'hFF);
    chk("oor_rdcnt", rd_cnt - r0, 0);

    // Second strobe during FETCH is ignored
    r0 = rd_cnt;
    ioctl_rd = 1'b1; ioctl_addr = 25'd5;
    step;
    ioctl_addr = 25'd6;
    step;
    ioctl_rd = 1'b0;
    n = 0;
    while (ioctl_wait && n < 20) begin n++; step; end
    chk("ign_din", ioctl_din, 8'hA7);
    chk("ign_rdcnt", rd_cnt - r0, 1);

    // Upload falls mid-fetch: fetch completes, then session ends
    d0 = done_cnt;
    ioctl_rd = 1'b1; ioctl_addr = 25'd7;
    step;
    ioctl_rd = 1'b0; ioctl_upload = 1'b0;
    n = 0;
    while (ioctl_wait && n < 20) begin n++; step; end
    chk("end_din", ioctl_din, 8'h3C);
    chk("end_busy_ready", busy, 1'b1);
    step;
    chk("end_done", done, 1'b1);
    chk("end_busy", busy, 1'b0);
    chk("end_pause", pause_req, 1'b0);
    step;
    chk("end_done_off", done, 1'b0);
    chk("end_done_cnt", done_cnt - d0, 1);

    // Asynchronous reset during FETCH
    ioctl_upload = 1'b1;
    step;
    step;
    chk("rs_ready_wait", ioctl_wait, 1'b0);
    d0 = done_cnt;
    ioctl_rd = 1'b1; ioctl_addr = 25'd2;
    step;
    ioctl_rd = 1'b0;
    chk("rs_ramrd", ram_rd, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rs_ramrd_clr", ram_rd, 1'b0);
    chk("rs_wait", ioctl_wait, 1'b0);
    chk("rs_busy", busy, 1'b0);
    chk("rs_pause", pause_req, 1'b0);
    chk("rs_din", ioctl_din, 8'h00);
    ioctl_upload = 1'b0;
    repeat (3) step;
    chk("rs_done", done, 1'b0);
    chk("rs_done_cnt", done_cnt - d0, 0);
    reset = 1'b0;
    step;

`ifdef HISCORE_UPLOAD_CHECKSUM_EN
    mem[0] = 8'h80; mem[1] = 8'h80; mem[2] = 8'h01; mem[3] = 8'h02;
    ioctl_upload = 1'b1;
    step;
    chk("cs_clear", checksum, 8'h00);
    step;
    for (int i = 0; i < 4; i++) do_read(25'(i), n);
    do_read(25'd2000, n);
    chk("cs_sum", checksum, 8'h03);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
